dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Two-requester arbiter that shares the single-port DRAM between two matrix-multiply cores. It sits between the cores' DRAM ports and the DRAM macro, all on the divided system clock. It grants exclusive DRAM ownership with round-robin fairness and a bounded burst length. It returns read data to the requester that issued the read, after the DRAM's fixed read latency.

## Interface
- ADDR_W, 16, DRAM address width
- DATA_W, 8, DRAM data width
- RD_LAT, 1, cycles from DRAM rden to valid q (range 1..4)
- MAX_BURST, 16, accepted accesses per tenure before yielding to a waiting requester (≥1)

- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_req0 / i_req1  in  1  requester n wants an access this cycle
- i_we0 / i_we1  in  1  1 = write, 0 = read; qualified by i_reqN
- i_addr0 / i_addr1  in  ADDR_W  access address
- i_wdata0 / i_wdata1  in  DATA_W  write data
- o_gnt0 / o_gnt1  out  1  requester n owns DRAM this cycle
- o_rvalid0 / o_rvalid1  out  1  read data for requester n valid this cycle
- o_rdata0 / o_rdata1  out  DATA_W  read data; 0 when o_rvalidN=0
- o_dram_addr  out  ADDR_W  to DRAM address
- o_dram_read  out  1  to DRAM rden
- o_dram_write  out  1  to DRAM wren
- o_dram_out  out  DATA_W  to DRAM data
- i_dram_in  in  DATA_W  DRAM q

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, last_owner (1 bit), burst count (saturating at MAX_BURST), read-return pipe of RD_LAT entries {valid, id}.
- Reset: state=IDLE, last_owner=1 (requester 0 wins the first tie), count=0, pipe cleared.
- o_gntN = (state==OWNn). Decoded from state only, with no combinational path from i_req.
- Accepted access: a cycle with o_gntN & i_reqN. The DRAM port is driven combinationally from requester n: addr, data, read=~we, write=we.
- When nothing is accepted, o_dram_read=o_dram_write=0, o_dram_addr=0, o_dram_out=0. This covers IDLE and any cycle where the owner drops i_req.
- IDLE transitions:
  - one request -> OWN of that requester;
  - both -> OWN of the requester ≠ last_owner;
  - none -> stay.
- OWNn transitions, evaluated each cycle; count_next is the count after this cycle's acceptance:
  - i_reqn=0 and other requesting -> OWN(other).
  - i_reqn=0 and no other request -> IDLE.
  - i_reqn=1, other requesting, count_next ≥ MAX_BURST -> OWN(other). This cycle's access is still accepted.
  - otherwise -> stay. The count saturates; the owner may continue indefinitely while the other is idle.
- Entering any OWN state: count=0, last_owner=new owner.
- Read return: each accepted read pushes {1, n} into the pipe. The entry exits RD_LAT cycles later, asserting o_rvalidN with o_rdataN=i_dram_in. Writes push {0, x}.
- Read data routing follows the issuing requester even if ownership changed in between.

## Timing
- Grant latency: a request arriving while IDLE gets o_gnt on the next cycle, and its first access is accepted in that cycle.
- Handoff is direct OWN0<->OWN1 with no idle cycle. The new owner's first access is one cycle after the switch decision.
- Read latency seen by a requester: RD_LAT cycles from the accepted cycle to o_rvalid.
- Throughput: one access per cycle while the owner holds i_req high.
- At most one o_rvalid is high per cycle; the two are never high together.
- Reset mid-operation: the next cycle is IDLE with all outputs 0. In-flight reads are dropped and produce no o_rvalid.
- A requester must hold i_addr, i_we and i_wdata stable and keep i_req high until it observes o_gnt. An access is complete only on an accepted cycle.

## Test plan
- Reset, then idle: all outputs 0, state IDLE for 10 cycles.
- Single read:
  - setup: DRAM[0x0010]=0xA5; i_req0=1, i_we0=0, i_addr0=0x0010 from cycle 0;
  - required: o_gnt0 at cycle 1, o_dram_read=1 at cycle 1, o_rvalid0=1 with o_rdata0=0xA5 at cycle 1+RD_LAT, o_rvalid1 never asserted.
- Simultaneous first request:
  - stimulus: i_req0 and i_req1 rise in the same cycle after reset;
  - required: requester 0 granted first.
  - stimulus: release and re-request both together;
  - required: requester 1 granted.
- Burst limit:
  - stimulus: MAX_BURST=4, requester 0 streams writes to 0x0000..; requester 1 requests at 0x0100 from cycle 2;
  - required: exactly 4 accepted writes from requester 0, then o_gnt1 the next cycle with no idle gap; requester 0 regains the grant after requester 1 reaches 4 accesses or releases.
- Cross-handoff read routing:
  - stimulus: requester 0's last accepted access is a read of 0x0020 (=0x3C), then ownership switches to requester 1;
  - required: 0x3C appears on o_rdata0 with o_rvalid0 only, RD_LAT cycles after acceptance.
- Reset mid-burst:
  - stimulus: assert i_rst for 1 cycle while requester 1 has a read in flight;
  - required: no o_rvalid1 for that read, state IDLE, requester 0 wins the next tie.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter
// ------------------------------------------------------------------
// Shares one single-port DRAM between two requesters (matrix-multiply
// cores). Ownership is granted exclusively with round-robin fairness on
// ties. An owner is forced to yield to a waiting peer after MAX_BURST
// accepted accesses. Read data is routed back to whichever requester
// issued the read, RD_LAT cycles after the read was accepted, even if
// ownership has changed in the meantime.
//
// Ports
//   i_clk, i_rst             clock (rising edge), synchronous active-high reset
//   i_reqN, i_weN            access request / write-not-read for requester N
//   i_addrN, i_wdataN        access address / write data for requester N
//   o_gntN                   requester N owns the DRAM this cycle (state decode)
//   o_rvalidN, o_rdataN      read return for requester N (data 0 when not valid)
//   o_dram_addr/_read/_write/_out   DRAM macro controls, driven from the owner
//   i_dram_in                DRAM q, valid RD_LAT cycles after rden
// ------------------------------------------------------------------
module dram_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [ADDR_W-1:0] o_dram_addr,
    output logic              o_dram_read,
    output logic              o_dram_write,
    output logic [DATA_W-1:0] o_dram_out,
    input  logic [DATA_W-1:0] i_dram_in
);

    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                last_owner_r;
    logic                last_owner_next_s;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_next_s;
    logic [CNT_W-1:0]    count_inc_s;
    logic                enter_own_s;

    logic                accept0_s;
    logic                accept1_s;
    logic                accept_any_s;
    logic                push_read_s;

    // Read-return pipe: bit k is the entry that has travelled k+1 cycles.
    logic [RD_LAT-1:0]   pipe_valid_r;
    logic [RD_LAT-1:0]   pipe_id_r;

    // Burst counter increment that sticks at MAX_BURST, so a lone owner
    // can stream indefinitely without the counter wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt >= MAX_CNT) begin
            res = MAX_CNT;
        end else begin
            res = cnt + CNT_W'(1);
        end
        return res;
    endfunction

    // Grants come straight from the state register; no path from i_req.
    assign o_gnt0 = (state_r == OWN0);
    assign o_gnt1 = (state_r == OWN1);

    assign accept0_s    = o_gnt0 & i_req0;
    assign accept1_s    = o_gnt1 & i_req1;
    assign accept_any_s = accept0_s | accept1_s;
    assign push_read_s  = (accept0_s & ~i_we0) | (accept1_s & ~i_we1);
    assign count_inc_s  = sat_inc(count_r);

    // DRAM port mux: the accepted owner drives the macro, otherwise all zero.
    always_comb begin
        o_dram_addr  = {ADDR_W{1'b0}};
        o_dram_out   = {DATA_W{1'b0}};
        o_dram_read  = 1'b0;
        o_dram_write = 1'b0;
        if (accept0_s) begin
            o_dram_addr  = i_addr0;
            o_dram_out   = i_wdata0;
            o_dram_read  = ~i_we0;
            o_dram_write = i_we0;
        end else if (accept1_s) begin
            o_dram_addr  = i_addr1;
            o_dram_out   = i_wdata1;
            o_dram_read  = ~i_we1;
            o_dram_write = i_we1;
        end else begin
            o_dram_addr  = {ADDR_W{1'b0}};
            o_dram_out   = {DATA_W{1'b0}};
            o_dram_read  = 1'b0;
            o_dram_write = 1'b0;
        end
    end

    // Ownership next-state: tie-break on last_owner, yield on release or
    // when the burst budget is used up while the peer is waiting.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_req0 && i_req1) begin
                    if (last_owner_r) begin
                        state_next_s = OWN0;
                    end else begin
                        state_next_s = OWN1;
                    end
                end else if (i_req0) begin
                    state_next_s = OWN0;
                end else if (i_req1) begin
                    state_next_s = OWN1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            OWN0: begin
                if (!i_req0) begin
                    if (i_req1) begin
                        state_next_s = OWN1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else if (i_req1 && (count_inc_s >= MAX_CNT)) begin
                    // This cycle's access is still accepted before the handoff.
                    state_next_s = OWN1;
                end else begin
                    state_next_s = OWN0;
                end
            end
            OWN1: begin
                if (!i_req1) begin
                    if (i_req0) begin
                        state_next_s = OWN0;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else if (i_req0 && (count_inc_s >= MAX_CNT)) begin
                    state_next_s = OWN0;
                end else begin
                    state_next_s = OWN1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Burst count / last owner: a fresh tenure restarts the count and
    // records the new owner for the next tie-break.
    always_comb begin
        enter_own_s = (state_next_s != state_r) && (state_next_s != IDLE);
        if (enter_own_s) begin
            count_next_s      = {CNT_W{1'b0}};
            last_owner_next_s = (state_next_s == OWN1);
        end else if (accept_any_s) begin
            count_next_s      = count_inc_s;
            last_owner_next_s = last_owner_r;
        end else begin
            count_next_s      = count_r;
            last_owner_next_s = last_owner_r;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
            count_r      <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            last_owner_r <= last_owner_next_s;
            count_r      <= count_next_s;
        end
    end

    // Read-return pipe: tags each accepted read with its issuer so the data
    // arriving RD_LAT cycles later is steered correctly. Reset drops all
    // in-flight reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_valid_r <= {RD_LAT{1'b0}};
            pipe_id_r    <= {RD_LAT{1'b0}};
        end else begin
            pipe_valid_r[0] <= push_read_s;
            pipe_id_r[0]    <= accept1_s;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_valid_r[k] <= pipe_valid_r[k-1];
                pipe_id_r[k]    <= pipe_id_r[k-1];
            end
        end
    end

    assign o_rvalid0 = pipe_valid_r[RD_LAT-1] & ~pipe_id_r[RD_LAT-1];
    assign o_rvalid1 = pipe_valid_r[RD_LAT-1] &  pipe_id_r[RD_LAT-1];
    assign o_rdata0  = o_rvalid0 ? i_dram_in : {DATA_W{1'b0}};
    assign o_rdata1  = o_rvalid1 ? i_dram_in : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dram_arbiter.sv
// Testbench for dram_arbiter: DRAM macro model, queue-based requester
// agents and a transaction-level reference model of ownership, burst
// limit and read-return routing.
module tb_dram_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int LAT = 2;
    localparam int MB  = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_req0, i_req1, i_we0, i_we1;
    logic [AW-1:0] i_addr0, i_addr1;
    logic [DW-1:0] i_wdata0, i_wdata1;
    logic          o_gnt0, o_gnt1, o_rvalid0, o_rvalid1;
    logic [DW-1:0] o_rdata0, o_rdata1;
    logic [AW-1:0] o_dram_addr;
    logic          o_dram_read, o_dram_write;
    logic [DW-1:0] o_dram_out;
    logic [DW-1:0] i_dram_in;

    always #5 i_clk = ~i_clk;

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .MAX_BURST(MB)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
        .i_addr0(i_addr0), .i_addr1(i_addr1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
        .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .o_dram_addr(o_dram_addr), .o_dram_read(o_dram_read),
        .o_dram_write(o_dram_write), .o_dram_out(o_dram_out),
        .i_dram_in(i_dram_in)
    );

    // DRAM macro model with fixed read latency
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] dq  [LAT];
    always @(posedge i_clk) begin
        if (o_dram_write) mem[o_dram_addr] = o_dram_out;
        dq[0] <= o_dram_read ? mem[o_dram_addr] : 8'h00;
        for (int k = 1; k < LAT; k++) dq[k] <= dq[k-1];
    end
    assign i_dram_in = dq[LAT-1];

    // Reference model state
    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } acc_t;
    typedef struct { int due; int id; logic [DW-1:0] data; } ret_t;
    acc_t          q0[$];
    acc_t          q1[$];
    ret_t          rq[$];
    logic [DW-1:0] ref_mem [0:65535];
    int            m_owner, m_last, m_cnt, cyc;
    int            checks = 0;
    int            errors = 0;
    bit            agent_en;
    int            rv0_3c, rv1_seen, acc0_before1;
    bit            seen_gnt1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_agent();
        if (agent_en) begin
            i_req0 = (q0.size() > 0);
            i_req1 = (q1.size() > 0);
            if (q0.size() > 0) begin
                i_we0 = q0[0].we; i_addr0 = q0[0].addr; i_wdata0 = q0[0].wdata;
            end else begin
                i_we0 = 1'b0; i_addr0 = 16'h0000; i_wdata0 = 8'h00;
            end
            if (q1.size() > 0) begin
                i_we1 = q1[0].we; i_addr1 = q1[0].addr; i_wdata1 = q1[0].wdata;
            end else begin
                i_we1 = 1'b0; i_addr1 = 16'h0000; i_wdata1 = 8'h00;
            end
        end
    endtask

    // One cycle of the reference model: predict, compare, advance.
    task automatic model_check();
        bit            req [2];
        logic          we  [2];
        logic [AW-1:0] ad  [2];
        logic [DW-1:0] wd  [2];
        int            acc_id, nxt, other;
        logic          e_rv0, e_rv1;
        logic [DW-1:0] e_rd0, e_rd1;
        ret_t          r;
        req[0] = i_req0; req[1] = i_req1;
        we[0] = i_we0;   we[1] = i_we1;
        ad[0] = i_addr0; ad[1] = i_addr1;
        wd[0] = i_wdata0; wd[1] = i_wdata1;
        acc_id = (m_owner >= 0 && req[m_owner]) ? m_owner : -1;
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = 8'h00; e_rd1 = 8'h00;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.id == 0) begin e_rv0 = 1'b1; e_rd0 = r.data; end
            else begin e_rv1 = 1'b1; e_rd1 = r.data; end
        end
        chk("gnt0",   32'(o_gnt0),   32'(m_owner == 0));
        chk("gnt1",   32'(o_gnt1),   32'(m_owner == 1));
        chk("dram_read",  32'(o_dram_read),  32'(acc_id >= 0 && !we[acc_id >= 0 ? acc_id : 0]));
        chk("dram_write", 32'(o_dram_write), 32'(acc_id >= 0 && we[acc_id >= 0 ? acc_id : 0]));
        chk("dram_addr",  32'(o_dram_addr),  acc_id >= 0 ? 32'(ad[acc_id]) : 32'd0);
        chk("dram_out",   32'(o_dram_out),   acc_id >= 0 ? 32'(wd[acc_id]) : 32'd0);
        chk("rvalid0", 32'(o_rvalid0), 32'(e_rv0));
        chk("rvalid1", 32'(o_rvalid1), 32'(e_rv1));
        chk("rdata0",  32'(o_rdata0),  32'(e_rd0));
        chk("rdata1",  32'(o_rdata1),  32'(e_rd1));
        // observation counters for directed scenarios
        if (o_rvalid0 === 1'b1 && o_rdata0 === 8'h3C) rv0_3c++;
        if (o_rvalid1 === 1'b1) rv1_seen++;
        if (!seen_gnt1) begin
            if (o_gnt1 === 1'b1) seen_gnt1 = 1'b1;
            else if (o_gnt0 === 1'b1 && o_dram_write === 1'b1) acc0_before1++;
        end
        // memory effects of the accepted access
        if (acc_id >= 0) begin
            if (we[acc_id]) ref_mem[ad[acc_id]] = wd[acc_id];
            else begin
                r.due = cyc + LAT; r.id = acc_id; r.data = ref_mem[ad[acc_id]];
                rq.push_back(r);
            end
        end
        // ownership rules
        if (m_owner < 0) begin
            if (req[0] && req[1]) nxt = 1 - m_last;
            else if (req[0]) nxt = 0;
            else if (req[1]) nxt = 1;
            else nxt = -1;
        end else begin
            other = 1 - m_owner;
            nxt = m_owner;
            if (!req[m_owner]) nxt = req[other] ? other : -1;
            else begin
                m_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
                if (req[other] && m_cnt >= MB) nxt = other;
            end
        end
        if (nxt >= 0 && nxt != m_owner) begin m_cnt = 0; m_last = nxt; end
        m_owner = nxt;
        if (agent_en && acc_id == 0) void'(q0.pop_front());
        if (agent_en && acc_id == 1) void'(q1.pop_front());
        cyc++;
    endtask

    task automatic tick();
        apply_agent();
        #1;
        model_check();
        @(negedge i_clk);
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1;
        q0.delete(); q1.delete();
        i_req0 = 1'b0; i_req1 = 1'b0; i_we0 = 1'b0; i_we1 = 1'b0;
        i_addr0 = 16'h0000; i_addr1 = 16'h0000; i_wdata0 = 8'h00; i_wdata1 = 8'h00;
        repeat (n) @(negedge i_clk);
        i_rst = 1'b0;
        m_owner = -1; m_last = 1; m_cnt = 0; rq.delete();
    endtask

    task automatic push(input int n, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_t x;
        x.we = we; x.addr = a; x.wdata = d;
        if (n == 0) q0.push_back(x); else q1.push_back(x);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[16'h0010] = 8'hA5; ref_mem[16'h0010] = 8'hA5;
        mem[16'h0020] = 8'h3C; ref_mem[16'h0020] = 8'h3C;
        cyc = 0; agent_en = 1'b0;
        rv0_3c = 0; rv1_seen = 0; acc0_before1 = 0; seen_gnt1 = 1'b1;

        // reset then idle
        do_reset(2);
        repeat (10) tick();

        // simultaneous first request, then release and re-request together
        i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 16'h0040; i_wdata0 = 8'h00;
        i_req1 = 1'b1; i_we1 = 1'b0; i_addr1 = 16'h0041; i_wdata1 = 8'h00;
        tick();
        chk("tie_first_gnt0", 32'(o_gnt0), 32'd1);
        tick();
        i_req0 = 1'b0; i_req1 = 1'b0;
        tick();
        i_req0 = 1'b1; i_req1 = 1'b1;
        tick();
        chk("tie_second_gnt1", 32'(o_gnt1), 32'd1);
        tick();
        i_req0 = 1'b0; i_req1 = 1'b0;
        repeat (LAT + 2) tick();

        // single read of 0x0010
        agent_en = 1'b1;
        rv1_seen = 0;
        push(0, 1'b0, 16'h0010, 8'h00);
        tick();
        chk("single_gnt0_c1", 32'(o_gnt0), 32'd1);
        repeat (LAT + 3) tick();
        chk("single_no_rvalid1", 32'(rv1_seen), 32'd0);

        // burst limit: requester 0 streams writes, requester 1 joins at cycle 2
        acc0_before1 = 0; seen_gnt1 = 1'b0;
        for (int i = 0; i < 8; i++) push(0, 1'b1, 16'(i), 8'($urandom));
        repeat (2) tick();
        for (int i = 0; i < 6; i++) push(1, 1'b1, 16'(16'h0100 + i), 8'($urandom));
        for (int i = 0; i < 60 && (q0.size() + q1.size()) > 0; i++) tick();
        chk("burst_drained", 32'(q0.size() + q1.size()), 32'd0);
        chk("burst_r0_count", 32'(acc0_before1), 32'd4);
        seen_gnt1 = 1'b1;
        repeat (LAT + 1) tick();

        // cross-handoff read routing: 4th access of the tenure reads 0x0020
        rv0_3c = 0;
        push(0, 1'b1, 16'h0030, 8'h11);
        push(0, 1'b1, 16'h0031, 8'h22);
        push(0, 1'b1, 16'h0032, 8'h33);
        push(0, 1'b0, 16'h0020, 8'h00);
        push(0, 1'b1, 16'h0033, 8'h44);
        tick();
        push(1, 1'b0, 16'h0010, 8'h00);
        push(1, 1'b1, 16'h0034, 8'h55);
        for (int i = 0; i < 40 && (q0.size() + q1.size()) > 0; i++) tick();
        repeat (LAT + 1) tick();
        chk("cross_rdata0_3c", 32'(rv0_3c), 32'd1);

        // reset while requester 1 has a read in flight
        push(1, 1'b0, 16'h0010, 8'h00);
        push(1, 1'b0, 16'h0011, 8'h00);
        repeat (2) tick();
        do_reset(1);
        rv1_seen = 0;
        repeat (LAT + 2) tick();
        chk("reset_drops_read", 32'(rv1_seen), 32'd0);
        push(0, 1'b0, 16'h0012, 8'h00);
        push(1, 1'b0, 16'h0013, 8'h00);
        tick();
        chk("reset_tie_gnt0", 32'(o_gnt0), 32'd1);
        for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) tick();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) != 0 && q0.size() < 3)
                push(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom));
            if ($urandom_range(0, 3) != 0 && q1.size() < 3)
                push(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom));
            tick();
        end
        for (int i = 0; i < 200 && (q0.size() + q1.size()) > 0; i++) tick();
        repeat (LAT + 2) tick();
        chk("final_queues_empty", 32'(q0.size() + q1.size()), 32'd0);
        chk("final_returns_done", 32'(rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
